// File: rtl/accel_sched_pkg.sv
// Shared encodings for the accelerator command scheduler: opcodes, FSM states,
// stage selectors and error causes.
package accel_sched_pkg;

  localparam logic [2:0] OP_PRE   = 3'd1;
  localparam logic [2:0] OP_ENC   = 3'd2;
  localparam logic [2:0] OP_SNN   = 3'd3;
  localparam logic [2:0] OP_CHAIN = 3'd4;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_DECODE  = 3'd1;
  localparam logic [2:0] ST_ISSUE   = 3'd2;
  localparam logic [2:0] ST_WAIT    = 3'd3;
  localparam logic [2:0] ST_ADVANCE = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  // Stage codes equal the single-stage opcodes so decode can reuse op[1:0].
  localparam logic [1:0] STG_NONE = 2'd0;
  localparam logic [1:0] STG_PRE  = 2'd1;
  localparam logic [1:0] STG_ENC  = 2'd2;
  localparam logic [1:0] STG_SNN  = 2'd3;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_ILLEGAL = 2'd2;

  function automatic logic op_is_legal(input logic [2:0] op);
    return (op == OP_PRE) || (op == OP_ENC) || (op == OP_SNN) || (op == OP_CHAIN);
  endfunction

endpackage

// File: rtl/sched_cmd_fifo.sv
// Synchronous command FIFO with full/empty flags; push and pop may share a cycle.
module sched_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
    mem_d    = mem_q;
    if (do_push) mem_d[wr_ptr_q[AW-1:0]] = wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/accel_cmd_sched.sv
// Queues CPU accelerator commands and sequences PRE/ENC/SNN start/done
// handshakes with a per-stage watchdog and a multi-frame CHAIN mode.
//
// state   | meaning
// IDLE    | waiting for a queued command; pops the head when one is present
// DECODE  | checks the opcode, selects the first stage, latches enc_sel
// ISSUE   | one-cycle start pulse for the current stage, watchdog cleared
// WAIT    | waiting for the current stage's done, watchdog running
// ADVANCE | picks the next CHAIN stage/frame or finishes
// DONE    | one-cycle sched_done pulse
module accel_cmd_sched
  import accel_sched_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT_W  = 16,
  parameter int FRAME_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_op,
  input  logic [1:0]           cmd_enc_sel,
  input  logic [FRAME_W-1:0]   cmd_frames,
  input  logic [TIMEOUT_W-1:0] timeout_cfg,
  output logic                 pre_start,
  output logic                 enc_start,
  output logic                 snn_start,
  output logic [1:0]           enc_sel_o,
  input  logic                 pre_done,
  input  logic                 enc_done,
  input  logic                 snn_done,
  output logic                 sched_busy,
  output logic                 sched_done,
  output logic                 sched_err,
  output logic [1:0]           err_code,
  input  logic                 err_clr,
  output logic [FRAME_W-1:0]   frame_cnt
);

  localparam int CMD_W = 3 + 2 + FRAME_W;

  logic [CMD_W-1:0]     fifo_rdata;
  logic                 fifo_full, fifo_empty, push, pop;
  logic [2:0]           state_q, state_d;
  logic [1:0]           stage_q, stage_d;
  logic [2:0]           cur_op_q, cur_op_d;
  logic [1:0]           cur_sel_q, cur_sel_d;
  logic [FRAME_W-1:0]   cur_frames_q, cur_frames_d;
  logic [1:0]           enc_sel_q, enc_sel_d;
  logic [FRAME_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic                 err_q, err_d;
  logic [1:0]           err_code_q, err_code_d;
  logic                 new_err, stage_done;
  logic [1:0]           err_cause;
  logic [FRAME_W-1:0]   frames_eff, frame_nxt;

  assign push = cmd_valid && !fifo_full;
  assign pop  = (state_q == ST_IDLE) && !fifo_empty;

  sched_cmd_fifo #(.WIDTH(CMD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({cmd_op, cmd_enc_sel, cmd_frames}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign stage_done = ((stage_q == STG_PRE) && pre_done) ||
                      ((stage_q == STG_ENC) && enc_done) ||
                      ((stage_q == STG_SNN) && snn_done);
  assign frames_eff = (cur_frames_q == '0) ? FRAME_W'(1) : cur_frames_q;
  assign frame_nxt  = frame_cnt_q + FRAME_W'(1);

  always_comb begin
    state_d      = state_q;
    stage_d      = stage_q;
    cur_op_d     = cur_op_q;
    cur_sel_d    = cur_sel_q;
    cur_frames_d = cur_frames_q;
    enc_sel_d    = enc_sel_q;
    frame_cnt_d  = frame_cnt_q;
    wd_d         = wd_q;
    new_err      = 1'b0;
    err_cause    = ERR_NONE;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          cur_op_d     = fifo_rdata[CMD_W-1 -: 3];
          cur_sel_d    = fifo_rdata[FRAME_W+1 -: 2];
          cur_frames_d = fifo_rdata[FRAME_W-1:0];
          state_d      = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (op_is_legal(cur_op_q)) begin
          stage_d   = (cur_op_q == OP_CHAIN) ? STG_PRE : cur_op_q[1:0];
          enc_sel_d = cur_sel_q;
          if (cur_op_q == OP_CHAIN) frame_cnt_d = '0;
          state_d   = ST_ISSUE;
        end else begin
          new_err   = 1'b1;
          err_cause = ERR_ILLEGAL;
          state_d   = ST_DONE;
        end
      end
      ST_ISSUE: begin
        wd_d    = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        wd_d = wd_q + TIMEOUT_W'(1);
        if (stage_done) begin
          state_d = ST_ADVANCE;
        end else if ((timeout_cfg != '0) && (wd_q == timeout_cfg - TIMEOUT_W'(1))) begin
          new_err   = 1'b1;
          err_cause = ERR_TIMEOUT;
          state_d   = ST_DONE;
        end
      end
      ST_ADVANCE: begin
        if (cur_op_q != OP_CHAIN) begin
          state_d = ST_DONE;
        end else if (stage_q == STG_PRE) begin
          stage_d = STG_ENC;
          state_d = ST_ISSUE;
        end else if (stage_q == STG_ENC) begin
          stage_d = STG_SNN;
          state_d = ST_ISSUE;
        end else begin
          frame_cnt_d = frame_nxt;
          if (frame_nxt == frames_eff) begin
            state_d = ST_DONE;
          end else begin
            stage_d = STG_PRE;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // A new error outranks a same-cycle clear; the first cause is kept.
    err_d      = err_q;
    err_code_d = err_code_q;
    if (new_err) begin
      err_d = 1'b1;
      if ((err_code_q == ERR_NONE) || err_clr) err_code_d = err_cause;
    end else if (err_clr) begin
      err_d      = 1'b0;
      err_code_d = ERR_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      stage_q      <= STG_NONE;
      cur_op_q     <= '0;
      cur_sel_q    <= '0;
      cur_frames_q <= '0;
      enc_sel_q    <= '0;
      frame_cnt_q  <= '0;
      wd_q         <= '0;
      err_q        <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      stage_q      <= stage_d;
      cur_op_q     <= cur_op_d;
      cur_sel_q    <= cur_sel_d;
      cur_frames_q <= cur_frames_d;
      enc_sel_q    <= enc_sel_d;
      frame_cnt_q  <= frame_cnt_d;
      wd_q         <= wd_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
    end
  end

  assign cmd_ready  = !fifo_full;
  assign pre_start  = (state_q == ST_ISSUE) && (stage_q == STG_PRE);
  assign enc_start  = (state_q == ST_ISSUE) && (stage_q == STG_ENC);
  assign snn_start  = (state_q == ST_ISSUE) && (stage_q == STG_SNN);
  assign enc_sel_o  = enc_sel_q;
  assign sched_busy = !fifo_empty || (state_q != ST_IDLE);
  assign sched_done = (state_q == ST_DONE);
  assign sched_err  = err_q;
  assign err_code   = err_code_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_accel_cmd_sched.sv
// Randomized bench for accel_cmd_sched against an event-timeline model of the
// scheduler: queue contents, per-command start sequence, retire cycle and errors.
module tb_accel_cmd_sched;

  localparam int DEPTH = 4;
  localparam int TW    = 16;
  localparam int FW    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_op = '0;
  logic [1:0]    cmd_enc_sel = '0;
  logic [FW-1:0] cmd_frames = '0;
  logic [TW-1:0] timeout_cfg = '0;
  logic          pre_start, enc_start, snn_start;
  logic [1:0]    enc_sel_o;
  logic          pre_done = 1'b0, enc_done = 1'b0, snn_done = 1'b0;
  logic          sched_busy, sched_done, sched_err;
  logic [1:0]    err_code;
  logic          err_clr = 1'b0;
  logic [FW-1:0] frame_cnt;

  always #5 clk = ~clk;

  accel_cmd_sched #(.FIFO_DEPTH(DEPTH), .TIMEOUT_W(TW), .FRAME_W(FW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_enc_sel(cmd_enc_sel), .cmd_frames(cmd_frames),
    .timeout_cfg(timeout_cfg), .pre_start(pre_start), .enc_start(enc_start),
    .snn_start(snn_start), .enc_sel_o(enc_sel_o), .pre_done(pre_done),
    .enc_done(enc_done), .snn_done(snn_done), .sched_busy(sched_busy),
    .sched_done(sched_done), .sched_err(sched_err), .err_code(err_code),
    .err_clr(err_clr), .frame_cnt(frame_cnt)
  );

  typedef struct {
    int op;
    int sel;
    int frames;
  } cmd_s;

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;

  // model state
  cmd_s mq[$];
  cmd_s force_q[$];
  cmd_s cur;
  bit   act = 0;
  int   evt_kind = 0;   // 0: next start, 1: retire
  int   evt_cyc = -1, evt_stage = 0, evt_cause = 0;
  bit   evt_err = 0;
  int   start_idx = 0, frames_done = 0;
  int   last_stage = 0, last_start_cyc = -1;
  int   done_cyc = -1, done_stage = 0;
  bit   m_err = 0;
  int   m_code = 0;
  bit   chk_rst_vals = 1;

  // knobs
  int   cfg_v = 0, p_valid = 0, p_hang = 0, max_dly = 4;
  bit   allow_cmd = 0, force_rst = 0, rst_armed = 0, rst_fired = 0;

  task automatic chk_eq(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic int stage_of(cmd_s c, int idx);
    return (c.op == 4) ? (idx % 3) + 1 : c.op;
  endfunction

  function automatic int n_starts(cmd_s c);
    return (c.op == 4) ? 3 * ((c.frames == 0) ? 1 : c.frames) : 1;
  endfunction

  function automatic bit legal(int op);
    return (op >= 1) && (op <= 4);
  endfunction

  function automatic cmd_s rand_cmd();
    cmd_s c;
    int r;
    r = $urandom_range(9);
    c.sel = $urandom_range(3);
    c.frames = $urandom_range(3);
    if (r < 2)       c.op = 4;
    else if (r == 9) begin
      case ($urandom_range(3))
        0: c.op = 0;
        1: c.op = 5;
        2: c.op = 6;
        default: c.op = 7;
      endcase
    end
    else             c.op = $urandom_range(1, 3);
    return c;
  endfunction

  // Called at the end of a start cycle: decide how the stage responds.
  task automatic plan_stage();
    int  k, r;
    bit  hang;
    last_stage     = evt_stage;
    last_start_cyc = cyc;
    hang = (cfg_v != 0) && ($urandom_range(99) < p_hang);
    r = $urandom_range(9);
    if (cfg_v != 0 && r < 2)      k = cfg_v;
    else if (cfg_v != 0 && r < 4) k = cfg_v + 1;
    else if (cfg_v > 1 && r < 5)  k = cfg_v - 1;
    else                          k = $urandom_range(1, max_dly);
    done_stage = evt_stage;
    if (cfg_v != 0 && (hang || k > cfg_v)) begin
      done_cyc  = (!hang && k == cfg_v + 1) ? cyc + k : -1;
      evt_kind  = 1;
      evt_cyc   = cyc + cfg_v + 1;
      evt_err   = 1;
      evt_cause = 1;
    end else begin
      done_cyc = cyc + k;
      if (cur.op == 4 && evt_stage == 3) frames_done++;
      start_idx++;
      evt_cyc = cyc + k + 2;
      evt_err = 0;
      if (start_idx < n_starts(cur)) begin
        evt_kind  = 0;
        evt_stage = stage_of(cur, start_idx);
      end else begin
        evt_kind = 1;
      end
    end
  endtask

  task automatic step();
    bit   is_start, is_retire, do_rst, acc, clr, newerr, from_force;
    int   noise;
    cmd_s nc;
    @(negedge clk);
    is_start  = act && evt_kind == 0 && evt_cyc == cyc;
    is_retire = act && evt_kind == 1 && evt_cyc == cyc;
    chk_eq("pre_start",  pre_start,  is_start && evt_stage == 1);
    chk_eq("enc_start",  enc_start,  is_start && evt_stage == 2);
    chk_eq("snn_start",  snn_start,  is_start && evt_stage == 3);
    chk_eq("sched_done", sched_done, is_retire);
    chk_eq("cmd_ready",  cmd_ready,  mq.size() < DEPTH);
    chk_eq("sched_busy", sched_busy, act || mq.size() > 0);
    chk_eq("sched_err",  sched_err,  m_err);
    chk_eq("err_code",   err_code,   m_code);
    if (is_start) chk_eq("enc_sel_start", enc_sel_o, cur.sel);
    if (is_retire && legal(cur.op)) chk_eq("enc_sel_retire", enc_sel_o, cur.sel);
    if (is_retire && cur.op == 4) chk_eq("frame_cnt", frame_cnt, frames_done);
    if (chk_rst_vals) begin
      chk_eq("rst_enc_sel", enc_sel_o, 0);
      chk_eq("rst_frame_cnt", frame_cnt, 0);
    end

    do_rst = force_rst || (rst_armed && act && cur.op == 4 && mq.size() == 2 &&
                           last_start_cyc >= 0 && last_start_cyc < cyc && done_cyc > cyc);
    rst = do_rst;
    from_force = 0;
    nc = rand_cmd();
    cmd_valid = 1'b0;
    if (!do_rst) begin
      if (force_q.size() > 0) begin
        cmd_valid = 1'b1;
        nc = force_q[0];
        from_force = 1;
      end else if (allow_cmd && $urandom_range(99) < p_valid) begin
        cmd_valid = 1'b1;
      end
    end
    cmd_op      = 3'(nc.op);
    cmd_enc_sel = 2'(nc.sel);
    cmd_frames  = FW'(nc.frames);
    timeout_cfg = TW'(cfg_v);

    // Stray dones of stages other than the one being waited on must be ignored.
    noise = ($urandom_range(99) < 15) ? $urandom_range(1, 3) : 0;
    if (act && noise == last_stage) noise = 0;
    pre_done = (done_cyc == cyc && done_stage == 1) || noise == 1;
    enc_done = (done_cyc == cyc && done_stage == 2) || noise == 2;
    snn_done = (done_cyc == cyc && done_stage == 3) || noise == 3;

    newerr = act && evt_kind == 1 && evt_cyc == cyc + 1 && evt_err;
    clr = !do_rst && ($urandom_range(99) < 4) && !(newerr && m_code != 0);
    err_clr = clr;

    if (do_rst) begin
      mq.delete();
      act = 0;
      m_err = 0;
      m_code = 0;
      done_cyc = -1;
      last_stage = 0;
      last_start_cyc = -1;
      chk_rst_vals = 1;
      if (rst_armed) rst_fired = 1;
      rst_armed = 0;
    end else begin
      chk_rst_vals = 0;
      acc = cmd_valid && (mq.size() < DEPTH);
      if (acc && from_force) void'(force_q.pop_front());
      if (newerr) begin
        m_err = 1;
        if (m_code == 0) m_code = evt_cause;
      end else if (clr) begin
        m_err = 0;
        m_code = 0;
      end
      if (act) begin
        if (evt_kind == 1 && evt_cyc == cyc) act = 0;
        else if (evt_kind == 0 && evt_cyc == cyc) plan_stage();
      end else if (mq.size() > 0) begin
        cur = mq.pop_front();
        act = 1;
        start_idx = 0;
        evt_cyc = cyc + 2;
        if (!legal(cur.op)) begin
          evt_kind = 1;
          evt_err = 1;
          evt_cause = 2;
        end else begin
          evt_kind = 0;
          evt_err = 0;
          evt_stage = stage_of(cur, 0);
          if (cur.op == 4) frames_done = 0;
        end
      end
      if (acc) mq.push_back(nc);
    end
    cyc++;
  endtask

  task automatic drain();
    int n;
    allow_cmd = 0;
    n = 0;
    while ((act || mq.size() > 0 || force_q.size() > 0) && n < 3000) begin
      step();
      n++;
    end
    chk_eq("drain_done", (act || mq.size() > 0) ? 0 : 1, 1);
  endtask

  task automatic run_phase(input int cfg, input int pv, input int ph, input int md, input int n);
    cfg_v = cfg;
    p_valid = pv;
    p_hang = ph;
    max_dly = md;
    allow_cmd = 1;
    repeat (n) step();
    drain();
  endtask

  initial begin
    cmd_s c;
    int   n;
    force_rst = 1;
    step();
    step();
    force_rst = 0;

    run_phase(0, 40, 0, 6, 1500);
    run_phase(10, 30, 25, 12, 1500);
    run_phase(1, 50, 20, 3, 800);
    run_phase(0, 90, 0, 25, 1500);

    // Reset while a CHAIN waits with two commands still queued.
    cfg_v = 0;
    p_hang = 0;
    max_dly = 8;
    c.op = 4; c.sel = 1; c.frames = 3; force_q.push_back(c);
    c.op = 1; c.sel = 2; c.frames = 0; force_q.push_back(c);
    c.op = 2; c.sel = 3; c.frames = 0; force_q.push_back(c);
    rst_armed = 1;
    n = 0;
    while (rst_armed && n < 400) begin
      step();
      n++;
    end
    rst_armed = 0;
    chk_eq("rst_fired", rst_fired, 1);
    repeat (30) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
